// File: rtl/multi_breath_pwm.sv
// Multi-channel breathing-LED driver: per-channel triangular PWM ramp on an
// active-low RGB LED, with per-channel speed, mode and colour rotation.
module multi_breath_pwm #(
   parameter int unsigned NCH   = 2,
   parameter int unsigned CW    = 16,
   parameter int unsigned BASE  = 1000,
   parameter int unsigned SEL_W = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NCH*SEL_W-1:0] freq,
   input  logic [NCH*2-1:0]     mode,
   output logic [NCH*3-1:0]     rgb_n,
   output logic [NCH-1:0]       breath_done,
   output logic [NCH-1:0]       busy
);

   localparam logic [1:0]    MODE_BREATHE = 2'b00;
   localparam logic [1:0]    MODE_STEADY  = 2'b01;
   localparam logic [1:0]    MODE_OFF     = 2'b10;
   localparam logic [1:0]    MODE_SHOT    = 2'b11;
   localparam logic [CW-1:0] ONE          = CW'(1);
   localparam logic [CW-1:0] BASE_CW      = CW'(BASE);

   for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
      logic [SEL_W-1:0] f_sel;
      logic [1:0]       m_sel;
      logic [CW-1:0]    cnt_q, cnt_d, level_q, level_d, p_q, p_d;
      logic [CW-1:0]    p_new, p_use;
      logic             dir_q, dir_d, shot_q, shot_d, init_q;
      logic [1:0]       col_q, col_d, mode_q;
      logic [2:0]       rgb_q, rgb_d, sel_n;
      logic             done_q, done_d, busy_q, busy_d;
      logic             restart, running, wrap;

      assign f_sel = freq[ch*SEL_W +: SEL_W];
      assign m_sel = mode[ch*2 +: 2];

      // Period candidate and per-cycle events; the first clock after reset uses the fresh period
      always_comb begin
         p_new   = BASE_CW * ((f_sel == '0) ? ONE : CW'(f_sel));
         p_use   = init_q ? p_new : p_q;
         restart = !init_q && (m_sel != mode_q) &&
                   (m_sel == MODE_BREATHE || m_sel == MODE_SHOT);
         running = !restart &&
                   (m_sel == MODE_BREATHE || (m_sel == MODE_SHOT && !shot_q));
         wrap    = (cnt_q == p_use - ONE);
      end

      // Next-state: ramp stepping, mode clears/freezes, colour rotation and period resample
      always_comb begin
         cnt_d   = cnt_q;
         level_d = level_q;
         dir_d   = dir_q;
         col_d   = col_q;
         shot_d  = shot_q;
         p_d     = init_q ? p_new : p_q;
         case (m_sel)
            MODE_OFF: begin
               cnt_d   = '0;
               level_d = '0;
               dir_d   = 1'b0;
               shot_d  = 1'b0;
            end
            MODE_STEADY: begin
            end
            default: begin
               if (!running) begin
                  cnt_d   = '0;
                  level_d = '0;
                  dir_d   = 1'b0;
               end else if (wrap) begin
                  cnt_d = '0;
                  if (!dir_q) begin
                     level_d = level_q + ONE;
                     if (level_q + ONE == p_use) dir_d = 1'b1;
                  end else begin
                     level_d = level_q - ONE;
                     if (level_q == ONE) begin
                        dir_d = 1'b0;
                        col_d = (col_q == 2'd2) ? 2'd0 : col_q + 2'd1;
                        p_d   = p_new;
                        if (m_sel == MODE_SHOT) shot_d = 1'b1;
                     end
                  end
               end else begin
                  cnt_d = cnt_q + ONE;
               end
            end
         endcase
      end

      // Output decode from the current state, registered below
      always_comb begin
         sel_n  = ~(3'b001 << col_q);
         rgb_d  = 3'b111;
         busy_d = 1'b0;
         done_d = 1'b0;
         case (m_sel)
            MODE_OFF: begin
            end
            MODE_STEADY: begin
               rgb_d  = sel_n;
               busy_d = (level_q != '0) || dir_q;
            end
            default: begin
               if (!restart) begin
                  if (cnt_q < level_q) rgb_d = sel_n;
                  busy_d = (level_q != '0) || dir_q;
                  done_d = running && wrap && dir_q && (level_q == ONE);
               end
            end
         endcase
      end

      // Channel state and output registers
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            cnt_q   <= '0;
            level_q <= '0;
            dir_q   <= 1'b0;
            col_q   <= 2'd0;
            shot_q  <= 1'b0;
            p_q     <= BASE_CW;
            init_q  <= 1'b1;
            mode_q  <= MODE_BREATHE;
            rgb_q   <= 3'b111;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
         end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
            dir_q   <= dir_d;
            col_q   <= col_d;
            shot_q  <= shot_d;
            p_q     <= p_d;
            init_q  <= 1'b0;
            mode_q  <= m_sel;
            rgb_q   <= rgb_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
         end
      end

      assign rgb_n[ch*3 +: 3] = rgb_q;
      assign breath_done[ch]  = done_q;
      assign busy[ch]         = busy_q;
   end

endmodule

// File: tb/tb_multi_breath_pwm.sv
// Bench for multi_breath_pwm: breath-position model plus directed literal checks.
module tb_multi_breath_pwm;

   localparam int NCH   = 2;
   localparam int CW    = 16;
   localparam int BASE  = 4;
   localparam int SEL_W = 4;

   logic                 clk;
   logic                 rst;
   logic [NCH*SEL_W-1:0] freq;
   logic [NCH*2-1:0]     mode;
   logic [NCH*3-1:0]     rgb_n;
   logic [NCH-1:0]       breath_done;
   logic [NCH-1:0]       busy;

   multi_breath_pwm #(.NCH(NCH), .CW(CW), .BASE(BASE), .SEL_W(SEL_W)) dut (
      .clk(clk), .rst(rst), .freq(freq), .mode(mode),
      .rgb_n(rgb_n), .breath_done(breath_done), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp;
   int n_bad;
   bit chk_en;

   // model: position t within the current breath, period, colour, shot flag
   int m_t[NCH], m_p[NCH], m_col[NCH], m_mq[NCH];
   bit m_shot[NCH], m_init[NCH];
   int e_rgb[NCH];
   bit e_done[NCH], e_busy[NCH];

   task automatic check(input string name, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < NCH; c++) begin
         m_t[c] = 0; m_p[c] = BASE; m_col[c] = 0; m_mq[c] = 0;
         m_shot[c] = 0; m_init[c] = 1;
         e_rgb[c] = 7; e_done[c] = 0; e_busy[c] = 0;
      end
   endtask

   task automatic model_step(input int c, input int m, input int f);
      int w, lvl, cnt, sel_n;
      bit dir, restart;
      restart = !m_init[c] && (m != m_mq[c]) && (m == 0 || m == 3);
      if (m_init[c]) m_p[c] = BASE * ((f == 0) ? 1 : f);
      w     = m_t[c] / m_p[c];
      lvl   = (w <= m_p[c]) ? w : 2 * m_p[c] - w;
      dir   = (w >= m_p[c]);
      cnt   = m_t[c] % m_p[c];
      sel_n = 7 ^ (1 << m_col[c]);
      e_done[c] = 0;
      if (m == 2) begin
         e_rgb[c] = 7; e_busy[c] = 0; m_t[c] = 0; m_shot[c] = 0;
      end else if (m == 1) begin
         e_rgb[c] = sel_n; e_busy[c] = (lvl != 0) || dir;
      end else if (restart) begin
         e_rgb[c] = 7; e_busy[c] = 0; m_t[c] = 0;
      end else begin
         e_rgb[c]  = (cnt < lvl) ? sel_n : 7;
         e_busy[c] = (lvl != 0) || dir;
         if (m == 3 && m_shot[c]) m_t[c] = 0;
         else begin
            m_t[c]++;
            if (m_t[c] == 2 * m_p[c] * m_p[c]) begin
               m_t[c] = 0;
               e_done[c] = 1;
               m_col[c] = (m_col[c] + 1) % 3;
               m_p[c] = BASE * ((f == 0) ? 1 : f);
               if (m == 3) m_shot[c] = 1;
            end
         end
      end
      m_mq[c] = m;
      m_init[c] = 0;
   endtask

   // model advance on each clock, async reset on rst fall
   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge rst);
         if (!rst) model_reset();
         else
            for (int c = 0; c < NCH; c++)
               model_step(c, int'(mode[c*2 +: 2]), int'(freq[c*SEL_W +: SEL_W]));
      end
   end

   // per-cycle comparison against the model
   initial begin
      forever begin
         @(negedge clk);
         if (chk_en)
            for (int c = 0; c < NCH; c++) begin
               check($sformatf("model rgb_n ch%0d", c), int'(rgb_n[c*3 +: 3]), e_rgb[c]);
               check($sformatf("model breath_done ch%0d", c), int'(breath_done[c]), int'(e_done[c]));
               check($sformatf("model busy ch%0d", c), int'(busy[c]), int'(e_busy[c]));
            end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   logic [2:0] seen0;
   int low0, lit1;

   task automatic step();
      @(posedge clk);
      #1;
      seen0 = seen0 | ~rgb_n[2:0];
      if (rgb_n[2:0] != 3'b111) low0++;
      if (rgb_n[5:3] != 3'b111) lit1++;
   endtask

   task automatic wait_done(input int ch, input int budget, output int n);
      n = 0; seen0 = '0; low0 = 0;
      do begin
         step();
         n++;
      end while (!breath_done[ch] && n < budget);
      if (!breath_done[ch]) begin
         n_cmp++; n_bad++;
         $display("FAIL timeout breath_done ch%0d: got none after %0d cycles", ch, n);
      end
   endtask

   task automatic count_pulses(input int ch, input int cycles, output int pulses);
      pulses = 0;
      for (int i = 0; i < cycles; i++) begin
         step();
         if (breath_done[ch]) pulses++;
      end
   endtask

   initial begin
      int n, pulses, same;
      logic [2:0] first;
      n_cmp = 0; n_bad = 0; chk_en = 0;
      seen0 = '0; low0 = 0; lit1 = 0;
      rst = 1'b0;
      freq = {4'd3, 4'd1};
      mode = 4'b0000;
      #1 chk_en = 1;
      repeat (3) @(posedge clk);
      #1;
      check("reset rgb_n", int'(rgb_n), 'h3F);
      check("reset busy", int'(busy), 0);
      check("reset breath_done", int'(breath_done), 0);
      rst = 1'b1;

      // basic breath on ch0 (P=4): 32-cycle breaths, colours R,G,B,R
      for (int b = 0; b < 4; b++) begin
         wait_done(0, 100, n);
         check($sformatf("ch0 breath %0d period", b), n, 32);
         check($sformatf("ch0 breath %0d colour", b), int'(seen0), 1 << (b % 3));
         if (b == 1) check("ch0 low cycles per breath", low0, 16);
      end

      // ch1 (P=12): first done at cycle 288, already 128 cycles in
      wait_done(1, 400, n);
      check("ch1 first breath remainder", n, 160);
      wait_done(1, 400, n);
      check("ch1 breath period", n, 288);
      repeat (100) step();
      freq[7:4] = 4'd1;
      wait_done(1, 400, n);
      check("ch1 period across freq change", n + 100, 288);
      wait_done(1, 400, n);
      check("ch1 period after resample", n, 32);

      // steady: constant single low pin, no done pulses
      mode[1:0] = 2'b01;
      step();
      first = rgb_n[2:0];
      same = 1; pulses = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (rgb_n[2:0] != first) same = 0;
         if (breath_done[0]) pulses++;
      end
      check("steady pin constant", same, 1);
      check("steady one pin low", $countones(first), 2);
      check("steady done pulses", pulses, 0);

      // off: all pins high, counters cleared
      mode[1:0] = 2'b10;
      step(); step();
      check("off rgb_n ch0", int'(rgb_n[2:0]), 7);
      check("off busy ch0", int'(busy[0]), 0);

      mode[1:0] = 2'b00;
      wait_done(0, 100, n);
      check("breathe restart after off", n, 33);

      // single-shot: one breath then dark and idle
      mode[1:0] = 2'b11;
      wait_done(0, 100, n);
      check("single-shot breath", n, 33);
      count_pulses(0, 200, pulses);
      check("single-shot extra pulses", pulses, 0);
      check("single-shot rgb_n after", int'(rgb_n[2:0]), 7);
      check("single-shot busy after", int'(busy[0]), 0);
      mode[1:0] = 2'b10;
      repeat (3) step();
      mode[1:0] = 2'b11;
      wait_done(0, 100, n);
      check("single-shot rearmed breath", n, 33);
      count_pulses(0, 100, pulses);
      check("single-shot rearmed extra pulses", pulses, 0);

      // freq=0 behaves as 1; ch1 off stays dark
      freq[3:0] = 4'd0;
      mode = 4'b1000;
      lit1 = 0;
      wait_done(0, 100, n);
      check("freq0 first breath", n, 33);
      wait_done(0, 100, n);
      check("freq0 resampled breath", n, 32);
      check("ch1 off lit cycles", lit1, 0);

      // reset at level 3 on the way down
      repeat (21) step();
      check("busy mid-breath", int'(busy[0]), 1);
      #1 rst = 1'b0;
      #1;
      check("async reset rgb_n", int'(rgb_n), 'h3F);
      check("async reset busy", int'(busy), 0);
      check("async reset breath_done", int'(breath_done), 0);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
      wait_done(0, 100, n);
      check("breath after reset", n, 32);
      check("colour after reset", int'(seen0), 1);
      repeat (5) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/multi_breath_pwm.md
# multi_breath_pwm

Parametrised multi-channel breathing-LED driver: a successor to the single-speed, two-instance RGB breath block. Each of NCH channels drives one active-low RGB LED with a symmetric triangular PWM brightness ramp. Each channel has its own speed select and mode (breathe, steady, off, single-shot), rotates colour R→G→B after every completed breath, and emits a breath-done pulse. The block sits between the board switches and the RGB LED pins in the top level.

## Interface
- NCH, 2: number of independent channels.
- CW, 16: width of the PWM and level counters; BASE*(2^SEL_W-1) must be < 2^CW.
- BASE, 1000: period unit in clk cycles; PWM period P = BASE*max(freq,1).
- SEL_W, 4: width of each channel's speed select.

Ports (clock and reset first):
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- freq  input  NCH*SEL_W  per-channel speed select; channel i uses bits [i*SEL_W +: SEL_W].
- mode  input  NCH*2  per-channel mode: 00 breathe, 01 steady, 10 off, 11 single-shot.
- rgb_n  output  NCH*3  per-channel {B,G,R}, active-low; channel i uses bits [i*3 +: 3].
- breath_done  output  NCH  one-cycle pulse per channel when its level returns to 0.
- busy  output  NCH  high while the channel is mid-breath (level≠0 or direction down).

## Operation
- Per-channel state:
  - cnt (CW bits), 0..P-1.
  - level (CW bits), 0..P.
  - dir: 0 = up, 1 = down.
  - col (2 bits): 0 = R, 1 = G, 2 = B.
  - P register.
  - shot_done flag.
- P sampling:
  - P is loaded from freq at reset release and at each breath completion only.
  - A freq change mid-breath does not alter the current ramp.
  - freq=0 is treated as 1.
- Breathe mode (00):
  - cnt increments every cycle and wraps P-1→0.
  - On each wrap with dir=up: level+1. If the new level == P, set dir=down.
  - On each wrap with dir=down: level-1. If the new level == 0:
    - set dir=up,
    - pulse breath_done,
    - advance col (2→0),
    - resample P.
  - A full breath is 2P wraps, i.e. 2·P² cycles.
- PWM output: on = (cnt < level). The selected colour pin is ~on; the other two pins are 1.
- Steady mode (01):
  - Selected colour pin is 0, the others 1.
  - Counters and col are frozen.
- Off mode (10):
  - All pins are 1.
  - cnt, level, dir and shot_done are cleared; col is held.
- Single-shot mode (11):
  - Behaves as breathe until the first breath_done.
  - Then sets shot_done; from that point all pins are 1 and the counters are held at 0.
  - shot_done clears only in off mode or on reset.
- Mode change to breathe or single-shot from any other mode restarts from cnt=0, level=0, dir=up.
- breath_done is not asserted in steady or off mode.
- Channels are fully independent; no shared counters.

## Timing
- Reset (rst=0, asynchronous) sets:
  - cnt=0, level=0, dir=up, col=R, shot_done=0, P=BASE*max(freq,1) sampled at the first clock after release.
  - rgb_n all 1s, breath_done=0, busy=0.
- All outputs are registered: rgb_n, breath_done and busy reflect the counter state of the previous cycle (latency 1).
- breath_done is high for exactly one clk cycle, in the cycle after level reaches 0.
- Simultaneous events:
  - A mode change in the same cycle as a wrap: the mode change wins and no level step occurs.
  - freq sampling coincides with breath_done: the new P governs the next cnt cycle.
- Reset mid-breath returns everything to reset values immediately, with no done pulse.
- Arithmetic:
  - level and cnt never exceed P.
  - Comparison is unsigned CW-bit.
  - BASE*freq is computed at CW bits with no overflow, per the parameter constraint.

## Test plan
- Basic breath: NCH=2, BASE=4, ch0 freq=1, mode=00 → P=4; breath_done[0] pulses every 32 cycles; ch0 colour sequence R,G,B,R on successive breaths; duty within a period goes 0/4,1/4,…,4/4,…,0/4.
- Speed and resample: ch1 freq=3 (P=12) → breath_done[1] every 288 cycles. Change freq to 1 mid-breath → current breath still 288 cycles, the next one 32.
- Steady and off: mode=01 → selected pin constant 0, no breath_done. mode=10 → rgb_n=3'b111 and counters cleared. Returning to 00 → ramp restarts at level 0 with colour unchanged.
- Single-shot: mode=11, P=4 → exactly one breath_done after 32 cycles, then rgb_n=111 and busy=0 indefinitely. Off then 11 again → one more breath.
- Reset mid-operation: assert rst low at level=3 going down → rgb_n=all 1s asynchronously and busy=0. After release, the first breath_done arrives 32 cycles later with colour R.
- freq=0 and independence: freq=0 behaves identically to freq=1. Driving ch0 with breathe and ch1 with off → ch1 pins stay 111 while ch0 breathes.
